alarma_ctrl: RTL and testbench
==============================

// Module: alarma_ctrl
// PURPOSE
//  Alarm sequencer for the clock: arms on switch, compares current HH:MM BCD digits to alarm digits at each
//  minute tick, drives buzzer while ringing, handles snooze/off buttons, ring timeout and snooze limit.
//  Sits between the time/alarm digit counters and the buzzer pin; replaces the bare compare-and-gate path.
// PARAMETERS
//  SNOOZE_MIN    5       minutes of silence per snooze (1..15)
//  RING_TO_S     60      seconds of ringing before automatic snooze (1..255)
//  MAX_SNOOZE    3       snoozes allowed per alarm event; next snooze/timeout returns to ARMED (1..7)
//  BEEP_HALF     25000   clk cycles per buzzer half-period (ALARMA_BEEP_EN only)
// PORTS
//  clk         in   1  system clock (single clock domain)
//  rst_n       in   1  asynchronous active-low reset
//  tick_seg    in   1  one-clk pulse per second
//  tick_min    in   1  one-clk pulse per minute; f0..f3 already hold the new minute in that cycle
//  f0..f3      in   4  current time BCD digits (f0 = minute units .. f3 = hour tens)
//  g0..g3      in   4  alarm time BCD digits, same ordering
//  alarm_en    in   1  alarm switch, level, synchronous to clk
//  btn_off     in   1  one-clk debounced pulse: stop alarm
//  btn_snooze  in   1  one-clk debounced pulse: snooze
//  son         out  1  buzzer drive
//  sonando     out  1  high in RINGING
//  pospuesto   out  1  high in SNOOZE
//  estado      out  2  state code (IDLE=0, ARMED=1, RINGING=2, SNOOZE=3)
// BEHAVIOUR
//  - Reset: estado=IDLE, son=0, sonando=0, pospuesto=0, all counters 0. All outputs registered.
//  - match = all four digit pairs equal, evaluated only in tick_min cycles.
//  - Priority per cycle: !alarm_en > btn_off > btn_snooze > timeout > tick events.
//  - IDLE: alarm_en=1 -> ARMED next cycle.
//  - ARMED: tick_min & match -> RINGING; ring_cnt=0, snz_num=0. Output goes high the cycle after tick_min.
//  - RINGING: btn_off -> ARMED. tick_seg increments ring_cnt; ring_cnt reaching RING_TO_S counts as snooze.
//    btn_snooze/timeout: if snz_num < MAX_SNOOZE -> SNOOZE, snz_left=SNOOZE_MIN, snz_num++; else -> ARMED.
//  - SNOOZE: tick_min decrements snz_left; tick_min with snz_left==1 -> RINGING, ring_cnt=0.
//    btn_off -> ARMED. btn_snooze ignored. A time match during SNOOZE is ignored.
//  - Any state, alarm_en=0 -> IDLE next cycle; son drops that same next cycle.
//  - No retrigger after btn_off within the alarm minute: match is only checked on tick_min edges.
//  - tick_seg and tick_min in the same cycle: both processed (ring_cnt and snz_left are separate counters).
//  - Alarm digits may change at any time; the change affects only the next tick_min compare.
//  - Digit width fixed at 4; ring_cnt 8b, snz_left 4b, snz_num 3b, saturating (never wraps).
// CONFIGURATION
//  ALARMA_BEEP_EN defined: son toggles every BEEP_HALF clk while RINGING, starting high on entry;
//    beep counter reset on every RINGING entry; son=0 outside RINGING.
//  ALARMA_BEEP_EN undefined: son = sonando (steady tone); no beep counter synthesized.
// STRUCTURE
//  Package alarma_pkg: state codes ST_IDLE..ST_SNOOZE, DIG_W=4, counter widths.
//  Sub-module beep_gen (clk, rst_n, en, son): half-period counter + toggle;
//    instantiated only under ALARMA_BEEP_EN.
//  Remainder (compare, FSM, counters) flat in alarma_ctrl.
// TESTING
//  1 alarm 07:30, en=1, tick_min with f=07:30 -> estado=2, sonando=1 next cycle; f=07:29 -> stays 1.
//  2 ringing, btn_snooze -> estado=3, son=0; 5 tick_min -> RINGING on 5th; btn_off -> ARMED.
//  3 ringing, no buttons, 60 tick_seg -> SNOOZE; repeat to 3 snoozes; 4th timeout -> ARMED, son=0.
//  4 btn_off and btn_snooze same cycle in RINGING -> ARMED; alarm_en=0 + btn_snooze -> IDLE.
//  5 rst_n low mid-RINGING -> all outputs 0/IDLE immediately; after release, en=1 -> ARMED.
//  6 ALARMA_BEEP_EN, BEEP_HALF=4: son pattern 1111 0000 1111 from RINGING entry; undefined: steady 1.

Source files
------------

// File: rtl/alarma_pkg.sv
// Shared types and widths for the alarm sequencer.
package alarma_pkg;

  localparam int unsigned DIG_W  = 4;
  localparam int unsigned RING_W = 8;
  localparam int unsigned SNZL_W = 4;
  localparam int unsigned SNZN_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_t;

endpackage

// File: rtl/alarma_if.sv
// Time/alarm digit bus plus second/minute ticks feeding the alarm sequencer.
interface alarma_if
  import alarma_pkg::*;
  ();

  logic             tick_seg;
  logic             tick_min;
  logic [DIG_W-1:0] f0, f1, f2, f3;
  logic [DIG_W-1:0] g0, g1, g2, g3;

  modport master (output tick_seg, tick_min, f0, f1, f2, f3, g0, g1, g2, g3);
  modport slave  (input  tick_seg, tick_min, f0, f1, f2, f3, g0, g1, g2, g3);

endinterface

// File: rtl/alarma_beep_gen.sv
// Buzzer tone generator: son toggles every HALF clocks while en, starting high.
module beep_gen #(
  parameter int unsigned HALF = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic son
);

  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             son_q, son_d;
  logic             act_q, act_d;

  always_comb begin
    cnt_d = cnt_q;
    son_d = son_q;
    act_d = act_q;
    if (!en) begin
      cnt_d = '0;
      son_d = 1'b0;
      act_d = 1'b0;
    end else if (!act_q) begin
      cnt_d = '0;
      son_d = 1'b1;
      act_d = 1'b1;
    end else if (cnt_q == CNT_W'(HALF - 1)) begin
      cnt_d = '0;
      son_d = ~son_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      son_q <= 1'b0;
      act_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      son_q <= son_d;
      act_q <= act_d;
    end
  end

  assign son = son_q;

endmodule

// File: rtl/alarma_ctrl.sv
// Alarm sequencer: arm, minute compare, ring, snooze, timeout and snooze limit.
// ALARMA_BEEP_EN selects a pulsed buzzer (beep_gen) instead of a steady tone.
module alarma_ctrl
  import alarma_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_TO_S  = 60,
  parameter int unsigned MAX_SNOOZE = 3
`ifdef ALARMA_BEEP_EN
  ,
  parameter int unsigned BEEP_HALF  = 25000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  alarma_if.slave    dig,
  input  logic       alarm_en,
  input  logic       btn_off,
  input  logic       btn_snooze,
  output logic       son,
  output logic       sonando,
  output logic       pospuesto,
  output logic [1:0] estado
);

  state_t              state_q, state_d;
  logic [RING_W-1:0]   ring_cnt_q, ring_cnt_d;
  logic [SNZL_W-1:0]   snz_left_q, snz_left_d;
  logic [SNZN_W-1:0]   snz_num_q, snz_num_d;
  logic                sonando_q, sonando_d;
  logic                pospuesto_q, pospuesto_d;
  logic                match, timeout;

  assign match = (dig.f0 == dig.g0) && (dig.f1 == dig.g1) &&
                 (dig.f2 == dig.g2) && (dig.f3 == dig.g3);
  assign timeout = (ring_cnt_q >= RING_W'(RING_TO_S));

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_left_d = snz_left_q;
    snz_num_d  = snz_num_q;
    if (!alarm_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED: begin
          if (dig.tick_min && match) begin
            state_d    = ST_RINGING;
            ring_cnt_d = '0;
            snz_num_d  = '0;
          end
        end
        ST_RINGING: begin
          if (btn_off) begin
            state_d = ST_ARMED;
          end else if (btn_snooze || timeout) begin
            if (snz_num_q < SNZN_W'(MAX_SNOOZE)) begin
              state_d    = ST_SNOOZE;
              snz_left_d = SNZL_W'(SNOOZE_MIN);
              if (snz_num_q != '1) snz_num_d = snz_num_q + SNZN_W'(1);
            end else begin
              state_d = ST_ARMED;
            end
          end else if (dig.tick_seg && ring_cnt_q != '1) begin
            ring_cnt_d = ring_cnt_q + RING_W'(1);
          end
        end
        ST_SNOOZE: begin
          if (btn_off) begin
            state_d = ST_ARMED;
          end else if (dig.tick_min) begin
            if (snz_left_q == SNZL_W'(1)) begin
              state_d    = ST_RINGING;
              ring_cnt_d = '0;
            end else if (snz_left_q != '0) begin
              snz_left_d = snz_left_q - SNZL_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    sonando_d   = (state_d == ST_RINGING);
    pospuesto_d = (state_d == ST_SNOOZE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ring_cnt_q  <= '0;
      snz_left_q  <= '0;
      snz_num_q   <= '0;
      sonando_q   <= 1'b0;
      pospuesto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ring_cnt_q  <= ring_cnt_d;
      snz_left_q  <= snz_left_d;
      snz_num_q   <= snz_num_d;
      sonando_q   <= sonando_d;
      pospuesto_q <= pospuesto_d;
    end
  end

`ifdef ALARMA_BEEP_EN
  // Fed from the next-state decode so the first beep lines up with sonando.
  beep_gen #(.HALF(BEEP_HALF)) u_beep (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sonando_d),
    .son   (son)
  );
`else
  logic son_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) son_q <= 1'b0;
    else        son_q <= sonando_d;
  end
  assign son = son_q;
`endif

  assign sonando   = sonando_q;
  assign pospuesto = pospuesto_q;
  assign estado    = state_q;

endmodule

// File: tb/tb_alarma_ctrl.sv
// Directed bench for alarma_ctrl; beep pattern checks follow ALARMA_BEEP_EN.
module tb_alarma_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alarm_en = 1'b0;
  logic       btn_off = 1'b0;
  logic       btn_snooze = 1'b0;
  logic       son, sonando, pospuesto;
  logic [1:0] estado;
  int         n_assert = 0;
  int         n_fail = 0;

  alarma_if dig ();

  always #5 clk = ~clk;

`ifdef ALARMA_BEEP_EN
  alarma_ctrl #(.SNOOZE_MIN(5), .RING_TO_S(60), .MAX_SNOOZE(3), .BEEP_HALF(4)) dut (
`else
  alarma_ctrl #(.SNOOZE_MIN(5), .RING_TO_S(60), .MAX_SNOOZE(3)) dut (
`endif
    .clk        (clk),
    .rst_n      (rst_n),
    .dig        (dig.slave),
    .alarm_en   (alarm_en),
    .btn_off    (btn_off),
    .btn_snooze (btn_snooze),
    .son        (son),
    .sonando    (sonando),
    .pospuesto  (pospuesto),
    .estado     (estado)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] st, input logic s, input logic r, input logic p);
    chk({tag, ".estado"}, 32'(estado), 32'(st));
    chk({tag, ".son"}, 32'(son), 32'(s));
    chk({tag, ".sonando"}, 32'(sonando), 32'(r));
    chk({tag, ".pospuesto"}, 32'(pospuesto), 32'(p));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input logic [3:0] h1, input logic [3:0] h0, input logic [3:0] m1, input logic [3:0] m0);
    dig.f3 = h1; dig.f2 = h0; dig.f1 = m1; dig.f0 = m0;
  endtask

  task automatic pulse_min();
    @(negedge clk) dig.tick_min = 1'b1;
    @(negedge clk) dig.tick_min = 1'b0;
  endtask

  task automatic pulse_seg(input int n);
    repeat (n) begin
      @(negedge clk) dig.tick_seg = 1'b1;
      @(negedge clk) dig.tick_seg = 1'b0;
    end
  endtask

  task automatic pulse_btn(input logic off, input logic snz);
    @(negedge clk) begin btn_off = off; btn_snooze = snz; end
    @(negedge clk) begin btn_off = 1'b0; btn_snooze = 1'b0; end
  endtask

  initial begin
    dig.tick_seg = 1'b0;
    dig.tick_min = 1'b0;
    dig.g3 = 4'd0; dig.g2 = 4'd7; dig.g1 = 4'd3; dig.g0 = 4'd0;
    set_time(4'd0, 4'd7, 4'd2, 4'd9);
    cyc(2);
    chk_out("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(2);
    chk("idle_no_en", 32'(estado), 32'd0);

    alarm_en = 1'b1;
    cyc(1);
    chk("arm", 32'(estado), 32'd1);

    pulse_min();
    chk("no_match_0729", 32'(estado), 32'd1);
    set_time(4'd0, 4'd7, 4'd3, 4'd0);
    pulse_min();
    chk_out("ring_0730", 2'd2, 1'b1, 1'b1, 1'b0);

    pulse_btn(1'b0, 1'b1);
    chk_out("snooze", 2'd3, 1'b0, 1'b0, 1'b1);
    pulse_btn(1'b0, 1'b1);
    chk("snooze_ignored", 32'(estado), 32'd3);
    repeat (4) pulse_min();
    chk("snooze_4min", 32'(estado), 32'd3);
    pulse_min();
    chk_out("resume_5th", 2'd2, 1'b1, 1'b1, 1'b0);
    pulse_btn(1'b1, 1'b0);
    chk_out("off", 2'd1, 1'b0, 1'b0, 1'b0);
    cyc(3);
    chk("no_retrigger", 32'(estado), 32'd1);
    set_time(4'd0, 4'd7, 4'd3, 4'd1);
    pulse_min();
    chk("no_match_0731", 32'(estado), 32'd1);

    set_time(4'd0, 4'd7, 4'd3, 4'd0);
    pulse_min();
    chk("ring_timeout_run", 32'(estado), 32'd2);
    for (int k = 0; k < 3; k++) begin
      pulse_seg(59);
      chk($sformatf("ring_59s_%0d", k), 32'(estado), 32'd2);
      pulse_seg(1);
      cyc(1);
      chk_out($sformatf("timeout_snz_%0d", k), 2'd3, 1'b0, 1'b0, 1'b1);
      repeat (5) pulse_min();
      chk($sformatf("timeout_resume_%0d", k), 32'(estado), 32'd2);
    end
    pulse_seg(60);
    cyc(1);
    chk_out("snooze_limit", 2'd1, 1'b0, 1'b0, 1'b0);

    pulse_min();
    chk("ring_again", 32'(estado), 32'd2);
    pulse_btn(1'b1, 1'b1);
    chk("off_beats_snooze", 32'(estado), 32'd1);
    pulse_min();
    chk("ring_for_disable", 32'(estado), 32'd2);
    @(negedge clk) begin alarm_en = 1'b0; btn_snooze = 1'b1; end
    @(negedge clk) btn_snooze = 1'b0;
    chk_out("disable_beats_snooze", 2'd0, 1'b0, 1'b0, 1'b0);

    alarm_en = 1'b1;
    cyc(1);
    chk("rearm", 32'(estado), 32'd1);
    pulse_min();
    chk("ring_for_reset", 32'(estado), 32'd2);
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("arm_after_reset", 32'(estado), 32'd1);

    dig.tick_min = 1'b1;
    @(negedge clk) dig.tick_min = 1'b0;
    for (int i = 0; i < 12; i++) begin
`ifdef ALARMA_BEEP_EN
      chk($sformatf("beep_%0d", i), 32'(son), 32'((i / 4) % 2 == 0));
`else
      chk($sformatf("steady_%0d", i), 32'(son), 32'd1);
`endif
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
